fifo_write_packer: RTL and testbench
====================================

// Module: fifo_write_packer
// PURPOSE
//  Upstream feeder for the async FIFO write port, in the clock_in domain. Packs a narrow byte
//  stream (valid/ready, last) into wide words and drives the FIFO write interface.
//  Each word carries a sideband byte count and a last flag.
//  Partial words are emitted on s_last or after an idle timeout.
// PARAMETERS
//  IN_WIDTH     8    width of one input lane
//  LANES        4    input lanes per output word (power of 2, >=2)
//  LANE_BITS    clogb2(LANES)-1 = 2   count field width
//  FLUSH_CYCLES 64   idle cycles before a partial word is flushed; 0 disables
//  OUT_WIDTH    LANES*IN_WIDTH+LANE_BITS+1 = 35   FIFO DATA_WIDTH
// PORTS
//  clock_in      in   1          write-domain clock
//  rst_in_n      in   1          reset, asynchronous, active-low
//  s_data        in   IN_WIDTH   input lane data
//  s_valid       in   1          s_data valid
//  s_last        in   1          final lane of packet
//  s_ready       out  1          input accepted when s_valid&&s_ready
//  data_in       out  OUT_WIDTH  word to FIFO: {last, nbytes-1, lanes}
//  data_in_valid out  1          word present
//  data_in_full  in   1          FIFO full; word accepted when data_in_valid&&!data_in_full
// BEHAVIOUR
//  - Reset (async): s_ready=1 after reset, data_in=0, data_in_valid=0, lane_cnt=0, idle_cnt=0, acc=0.
//  - Reset mid-packet discards the partial word and any unaccepted output word.
//  - Word format:
//    - lanes[LANES*IN_WIDTH-1:0]: lane 0 in the LSBs; unused lanes are zero.
//    - [OUT_WIDTH-2 -: LANE_BITS] = valid lanes - 1.
//    - [OUT_WIDTH-1] = last.
//  - Handshake:
//    - s_ready = !data_in_valid || !data_in_full.
//      It is combinational and independent of s_valid/s_last.
//    - data_in/data_in_valid are registered.
//    - While data_in_valid && data_in_full, data_in holds stable.
//  - Accumulate: on an accepted lane, acc[lane_cnt] <= s_data.
//    - If lane_cnt==LANES-1 or s_last, the word completes.
//      The output register loads {s_last, lane_cnt, acc|new lane}; data_in_valid <= 1.
//      lane_cnt <= 0; acc <= 0.
//    - Otherwise lane_cnt <= lane_cnt+1.
//  - Latency: completing lane -> data_in_valid one cycle later.
//    - Throughput is 1 lane/cycle while the FIFO is not full.
//  - Simultaneous drain+load: if the output word is accepted in the same cycle a new word completes,
//    the register reloads and data_in_valid stays 1 (no bubble).
//  - Drain only: accepted with nothing completing -> data_in_valid <= 0.
//  - Idle flush (FLUSH_CYCLES>0):
//    - idle_cnt counts cycles with lane_cnt!=0 and no accepted lane.
//    - It clears on any accepted lane or when lane_cnt==0.
//    - When idle_cnt==FLUSH_CYCLES-1 and s_ready, the partial word loads with last=0 and count=lane_cnt-1.
//    - Same clears as a completed word.
//    - If !s_ready at expiry, idle_cnt saturates and the flush fires at the first s_ready cycle.
//  - s_last on lane 0 gives a 1-lane word (count=0, last=1).
//  - lane_cnt wraps LANES-1 -> 0. No state machine beyond the lane_cnt/out-valid pair.
//  - No data is ever dropped. s_valid without s_ready is held by the source.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - clogb2 function.
//    - Word-field offset constants: LAST_BIT, CNT_LSB, DATA_MSB (used by the read-side unpacker).
//  - Single module, no sub-module. The idle counter is inline, width clogb2(FLUSH_CYCLES).
// TESTING
//  1. Reset, then 4 lanes 0x11,0x22,0x33,0x44 with last on 0x44, full=0
//     -> one cycle later data_in=0x7_44332211 (last=1, cnt=3), valid for 1 cycle.
//  2. 6 lanes 0xA0..0xA5 back-to-back, last on 0xA5
//     -> words 0x3_A3A2A1A0 then 0x5_0000A5A4 (cnt=1, last=1); s_ready never drops.
//  3. Hold data_in_full=1 with a word pending, feed 5 lanes
//     -> s_ready=0 from the cycle after load, data_in stable.
//     -> Release full -> word accepted, next word follows with no bubble.
//  4. Send 2 lanes 0x01,0x02 without last, idle 64 cycles
//     -> flush word 0x1_00000201 (last=0, cnt=1) on cycle 64 after the last lane.
//  5. Assert rst_in_n=0 with lane_cnt=2 and data_in_valid=1
//     -> data_in_valid=0, s_ready=1 immediately.
//     -> The next 4-lane packet produces a clean word with no stale lanes.
//  6. Random s_valid/data_in_full scoreboard of 10k lanes
//     -> byte order and last flags are preserved, zero loss or duplication.

Source files
------------

// File: rtl/fifo_write_packer_pkg.sv
// Shared constants and helpers for the byte-to-word FIFO packer and its read-side unpacker.
package fifo_write_packer_pkg;

  // Number of bits needed to represent value (clogb2(4) = 3, clogb2(64) = 7).
  function automatic int clogb2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value;
    while (v > 0) begin
      bits = bits + 1;
      v = v >> 1;
    end
    return bits;
  endfunction

  localparam int IN_WIDTH     = 8;
  localparam int LANES        = 4;
  localparam int LANE_BITS    = clogb2(LANES) - 1;
  localparam int FLUSH_CYCLES = 64;
  localparam int DATA_W       = LANES * IN_WIDTH;
  localparam int OUT_WIDTH    = DATA_W + LANE_BITS + 1;

  localparam int LAST_BIT = OUT_WIDTH - 1;
  localparam int CNT_LSB  = OUT_WIDTH - 1 - LANE_BITS;
  localparam int DATA_MSB = DATA_W - 1;

  function automatic logic [OUT_WIDTH-1:0] pack_word(
    input logic                 last,
    input logic [LANE_BITS-1:0] cnt,
    input logic [DATA_W-1:0]    lanes
  );
    return {last, cnt, lanes};
  endfunction

endpackage

// File: rtl/fifo_write_packer_if.sv
// Byte stream in, packed word out toward the async FIFO write port.
interface fifo_write_packer_if;
  import fifo_write_packer_pkg::*;

  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_full;

  modport master (
    input  s_data, s_valid, s_last, data_in_full,
    output s_ready, data_in, data_in_valid
  );

  modport slave (
    output s_data, s_valid, s_last, data_in_full,
    input  s_ready, data_in, data_in_valid
  );

endinterface

// File: rtl/fifo_write_packer.sv
// Packs a byte stream into {last, nbytes-1, lanes} words for the FIFO write port;
// partial words go out on s_last or after FLUSH_CYCLES idle cycles.
module fifo_write_packer
  import fifo_write_packer_pkg::*;
(
  input  logic                clock_in,
  input  logic                rst_in_n,
  fifo_write_packer_if.master bus
);

  localparam bit FLUSH_EN = (FLUSH_CYCLES > 0);
  localparam int IDLE_W   = FLUSH_EN ? clogb2(FLUSH_CYCLES) : 1;
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(FLUSH_EN ? FLUSH_CYCLES - 1 : 0);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);
  localparam logic [LANE_BITS-1:0] LANE_ZERO = {LANE_BITS{1'b0}};
  localparam logic [LANE_BITS-1:0] LANE_ONE  = LANE_BITS'(1);

  logic [LANE_BITS-1:0] lane_cnt_r;
  logic [IDLE_W-1:0]    idle_cnt_r;
  logic [DATA_W-1:0]    acc_r;
  logic [OUT_WIDTH-1:0] word_r;
  logic                 word_valid_r;

  logic                 s_ready_s;
  logic                 accept_s;
  logic                 drain_s;
  logic                 complete_s;
  logic                 flush_s;
  logic                 load_s;
  logic [DATA_W-1:0]    lane_word_s;
  logic [OUT_WIDTH-1:0] next_word_s;

  // The output slot is free when empty or being drained this cycle.
  assign s_ready_s         = !word_valid_r || !bus.data_in_full;
  assign drain_s           = word_valid_r && !bus.data_in_full;
  assign bus.s_ready       = s_ready_s;
  assign bus.data_in       = word_r;
  assign bus.data_in_valid = word_valid_r;

  // Merge the incoming lane, decide completion/flush and build the next output word.
  always_comb begin
    lane_word_s = acc_r;
    lane_word_s[lane_cnt_r*IN_WIDTH +: IN_WIDTH] = bus.s_data;

    accept_s   = bus.s_valid && s_ready_s;
    complete_s = accept_s && ((lane_cnt_r == LAST_LANE) || bus.s_last);
    // A flush never coincides with an accepted lane, so the two loads are exclusive.
    flush_s    = FLUSH_EN && !accept_s && s_ready_s &&
                 (lane_cnt_r != LANE_ZERO) && (idle_cnt_r == IDLE_MAX);
    load_s     = complete_s || flush_s;

    if (complete_s) begin
      next_word_s = pack_word(bus.s_last, lane_cnt_r, lane_word_s);
    end else begin
      next_word_s = pack_word(1'b0, lane_cnt_r - LANE_ONE, acc_r);
    end
  end

  // Output register, lane accumulator and idle-flush counter.
  always_ff @(posedge clock_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      word_r       <= {OUT_WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      lane_cnt_r   <= LANE_ZERO;
      acc_r        <= {DATA_W{1'b0}};
      idle_cnt_r   <= {IDLE_W{1'b0}};
    end else begin
      if (load_s) begin
        word_r       <= next_word_s;
        word_valid_r <= 1'b1;
      end else if (drain_s) begin
        word_valid_r <= 1'b0;
      end

      if (load_s) begin
        lane_cnt_r <= LANE_ZERO;
        acc_r      <= {DATA_W{1'b0}};
      end else if (accept_s) begin
        lane_cnt_r <= lane_cnt_r + LANE_ONE;
        acc_r      <= lane_word_s;
      end

      // Saturates at expiry so a flush blocked by a full FIFO fires on the first ready cycle.
      if (accept_s || load_s || (lane_cnt_r == LANE_ZERO)) begin
        idle_cnt_r <= {IDLE_W{1'b0}};
      end else if (idle_cnt_r != IDLE_MAX) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_packer.sv
// Directed and randomized checks of the byte-to-word FIFO packer.
module tb_fifo_write_packer;
  import fifo_write_packer_pkg::*;

  logic clock_in;
  logic rst_in_n;
  int   vectors;
  int   miscompares;

  fifo_write_packer_if bus();

  fifo_write_packer dut (
    .clock_in (clock_in),
    .rst_in_n (rst_in_n),
    .bus      (bus)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_in);
    #1;
  endtask

  task automatic lane(input logic [7:0] d, input logic l);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    cyc();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  logic [7:0]  lanes_m[$];
  logic [34:0] exp_q[$];
  logic [34:0] w;
  logic [34:0] held;
  int          n;
  int          sent;
  bit          hold;
  bit          acc_b;
  bit          drn_b;
  bit          rdy_ok;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_in_n     = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 8'h00;
    bus.s_last   = 1'b0;
    bus.data_in_full = 1'b0;
    #2;
    check("reset_valid", 64'(bus.data_in_valid), 64'h0);
    check("reset_data", 64'(bus.data_in), 64'h0);
    check("reset_ready", 64'(bus.s_ready), 64'h1);
    cyc();
    cyc();
    rst_in_n = 1'b1;
    cyc();

    // 1: single full packet
    lane(8'h11, 1'b0);
    lane(8'h22, 1'b0);
    lane(8'h33, 1'b0);
    lane(8'h44, 1'b1);
    check("t1_valid", 64'(bus.data_in_valid), 64'h1);
    check("t1_word", 64'(bus.data_in), 64'h7_4433_2211);
    cyc();
    check("t1_one_cycle", 64'(bus.data_in_valid), 64'h0);

    // 2: six lanes back to back
    rdy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA0 + 8'(i);
      bus.s_last  = (i == 5);
      #1;
      if (!bus.s_ready) rdy_ok = 1'b0;
      cyc();
      if (i == 3) begin
        check("t2_w0_valid", 64'(bus.data_in_valid), 64'h1);
        check("t2_w0", 64'(bus.data_in), 64'h3_A3A2_A1A0);
      end
      if (i == 4) check("t2_drained", 64'(bus.data_in_valid), 64'h0);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("t2_w1_valid", 64'(bus.data_in_valid), 64'h1);
    check("t2_w1", 64'(bus.data_in), 64'h5_0000_A5A4);
    check("t2_ready_steady", 64'(rdy_ok), 64'h1);
    cyc();

    // 3: backpressure with a held word, then no-bubble release
    bus.data_in_full = 1'b1;
    lane(8'hB0, 1'b0);
    lane(8'hB1, 1'b0);
    lane(8'hB2, 1'b0);
    lane(8'hB3, 1'b0);
    check("t3_word", 64'(bus.data_in), 64'h3_B3B2_B1B0);
    check("t3_ready_low", 64'(bus.s_ready), 64'h0);
    held = bus.data_in;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hB4;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t3_hold_ready", 64'(bus.s_ready), 64'h0);
      check("t3_hold_data", 64'(bus.data_in), 64'(held));
    end
    bus.data_in_full = 1'b0;
    #1;
    check("t3_release_ready", 64'(bus.s_ready), 64'h1);
    cyc();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("t3_no_bubble", 64'(bus.data_in_valid), 64'h1);
    check("t3_next_word", 64'(bus.data_in), 64'h4_0000_00B4);
    cyc();
    check("t3_drained", 64'(bus.data_in_valid), 64'h0);

    // 4: idle flush of a partial word
    lane(8'h01, 1'b0);
    lane(8'h02, 1'b0);
    n = 0;
    while (!bus.data_in_valid && n < 100) begin
      cyc();
      n++;
    end
    check("t4_flush_delay", 64'(n), 64'd64);
    check("t4_flush_word", 64'(bus.data_in), 64'h1_0000_0201);
    cyc();
    check("t4_drained", 64'(bus.data_in_valid), 64'h0);

    // 5: reset with a held word, reset mid-packet, then a clean packet
    bus.data_in_full = 1'b1;
    lane(8'h66, 1'b1);
    check("t5_held", 64'(bus.data_in_valid), 64'h1);
    rst_in_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus.data_in_valid), 64'h0);
    check("t5_rst_ready", 64'(bus.s_ready), 64'h1);
    check("t5_rst_data", 64'(bus.data_in), 64'h0);
    cyc();
    rst_in_n = 1'b1;
    bus.data_in_full = 1'b0;
    cyc();
    lane(8'h77, 1'b0);
    lane(8'h78, 1'b0);
    rst_in_n = 1'b0;
    #1;
    check("t5_partial_rst_valid", 64'(bus.data_in_valid), 64'h0);
    cyc();
    rst_in_n = 1'b1;
    cyc();
    lane(8'h91, 1'b0);
    lane(8'h92, 1'b0);
    lane(8'h93, 1'b0);
    lane(8'h94, 1'b1);
    check("t5_clean_word", 64'(bus.data_in), 64'h7_9493_9291);
    cyc();

    // 6: random valid/full scoreboard
    sent = 0;
    hold = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      if (!hold) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = 8'($urandom);
        bus.s_last  = (sent == 9999) || ($urandom_range(0, 7) == 0);
      end
      bus.data_in_full = ($urandom_range(0, 2) == 0);
      #1;
      acc_b = bus.s_valid && bus.s_ready;
      drn_b = bus.data_in_valid && !bus.data_in_full;
      if (drn_b) begin
        if (exp_q.size() == 0) begin
          check("t6_extra_word", 64'(bus.data_in), 64'h7FFF_FFFF_FFFF);
        end else begin
          check("t6_word", 64'(bus.data_in), 64'(exp_q.pop_front()));
        end
      end
      if (acc_b) begin
        lanes_m.push_back(bus.s_data);
        sent++;
        if (lanes_m.size() == 4 || bus.s_last) begin
          w = 35'h0;
          for (int i = 0; i < lanes_m.size(); i++) w[i*8 +: 8] = lanes_m[i];
          w[33:32] = 2'(lanes_m.size() - 1);
          w[34]    = bus.s_last;
          exp_q.push_back(w);
          lanes_m.delete();
        end
      end
      hold = bus.s_valid && !acc_b;
      cyc();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.data_in_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.data_in_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_extra_tail", 64'(bus.data_in), 64'h7FFF_FFFF_FFFF);
        end else begin
          check("t6_tail_word", 64'(bus.data_in), 64'(exp_q.pop_front()));
        end
      end
      cyc();
    end
    check("t6_lanes_sent", 64'(sent), 64'd10000);
    check("t6_words_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
